// File: rtl/mult_cell_sched.sv
// Round-robin sequencer sharing one 3-partial 16x16 multiplier cell between two requesters.
// Optional MULT_SCHED_ZERO_BYPASS_EN: zero operands skip the cell and respond with 0.
module mult_cell_sched #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    COMB,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_prio;
  logic        r_owner;
  logic [1:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_data;

  logic        w_idle;
  logic        w_g0;
  logic        w_g1;
  logic        w_acc;
  logic        w_zero;
  logic        w_last;
  logic        w_hs;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_mid;
  logic [31:0] w_sum;

  assign w_idle = (r_state == IDLE);
  assign w_g0   = req0_valid & (~req1_valid | ~r_prio);
  assign w_g1   = req1_valid & (~req0_valid | r_prio);
  assign w_a    = w_g1 ? req1_a : req0_a;
  assign w_b    = w_g1 ? req1_b : req0_b;

  // Gating with reset_n keeps the handshake low while reset is held.
  assign req0_ready = reset_n & w_idle & w_g0;
  assign req1_ready = reset_n & w_idle & w_g1;
  assign w_acc      = req0_ready | req1_ready;

`ifdef MULT_SCHED_ZERO_BYPASS_EN
  assign w_zero = (w_a == 32'd0) | (w_b == 32'd0);
`else
  assign w_zero = 1'b0;
`endif

  assign w_last = (r_cnt == 2'(LAT - 1));
  assign w_hs   = r_owner ? rsp1_ready : rsp0_ready;
  assign w_mid  = cell_p2 + cell_p3;
  assign w_sum  = cell_p1 + {w_mid[15:0], 16'd0};

  assign cell_src1  = r_a;
  assign cell_src2  = r_b;
  assign cell_en    = (r_state == MUL);
  assign rsp0_valid = (r_state == RESP) & ~r_owner;
  assign rsp1_valid = (r_state == RESP) & r_owner;
  assign rsp_data   = r_data;
  assign busy       = ~w_idle;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_acc) w_next = w_zero ? RESP : MUL;
      MUL:  if (w_last) w_next = COMB;
      COMB: w_next = RESP;
      RESP: if (w_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio  <= 1'b0;
      r_owner <= 1'b0;
      r_cnt   <= 2'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_data  <= 32'd0;
    end else begin
      if (w_acc) begin
        r_a     <= w_a;
        r_b     <= w_b;
        r_owner <= w_g1;
        r_prio  <= ~w_g1;
        r_cnt   <= 2'd0;
        if (w_zero) r_data <= 32'd0;
      end
      if (r_state == MUL) r_cnt <= r_cnt + 2'd1;
      // Partials are held here because cell_en is low in COMB.
      if (r_state == COMB) r_data <= w_sum;
    end
  end

endmodule

// File: tb/tb_mult_cell_sched.sv
// Scoreboard bench for mult_cell_sched with a behavioural LAT=1 multiplier cell.
// Expected products are pushed at accept and popped at the response handshake.
module tb_mult_cell_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_data;
  logic [31:0] cell_src1, cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1 = '0, cell_p2 = '0, cell_p3 = '0;
  logic        busy;

  mult_cell_sched #(.LAT(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data),
    .cell_src1(cell_src1), .cell_src2(cell_src2),
    .cell_en(cell_en),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cell_en) begin
      cell_p1 <= {16'd0, cell_src1[15:0]} * {16'd0, cell_src2[15:0]};
      cell_p2 <= {16'd0, cell_src1[15:0]} * {16'd0, cell_src2[31:16]};
      cell_p3 <= {16'd0, cell_src1[31:16]} * {16'd0, cell_src2[15:0]};
    end
  end

  typedef struct {
    bit          who;
    logic [31:0] d;
    int          lat;
    int          cen;
  } exp_t;

  exp_t sb[$];
  bit   grants[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   cen = 0;
  int   last_hs = 0;
  bit   prev_v = 0;
  bit   chk_b2b = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input bit who, input logic [31:0] a,
                              input logic [31:0] b);
    exp_t e;
    bit   z;
    z = (a == 0) || (b == 0);
    e.who = who;
    e.d   = a * b;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
    e.lat = z ? 1 : 3;
    e.cen = z ? 0 : 1;
`else
    e.lat = 3;
    e.cen = 1;
    if (z) e.d = 32'd0;
`endif
    return e;
  endfunction

  task automatic on_acc(input bit who, input logic [31:0] a,
                        input logic [31:0] b);
    sb.push_back(mk(who, a, b));
    grants.push_back(who);
    acc_cyc = cyc;
    cen = 0;
    if (chk_b2b) begin
      chk("b2b_accept_cycle", 64'(cyc), 64'(last_hs + 1));
      chk_b2b = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v = 0;
    end else begin
      if (req0_valid && req0_ready) on_acc(0, req0_a, req0_b);
      if (req1_valid && req1_ready) on_acc(1, req1_a, req1_b);
      if (cell_en) cen++;
      if (busy) chk("ready_while_busy", {req0_ready, req1_ready}, 0);
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_without_req", 1, 0);
        end else begin
          chk("rsp_owner", {rsp0_valid, rsp1_valid},
              sb[0].who ? 2'b01 : 2'b10);
          chk("rsp_data", rsp_data, sb[0].d);
          if (!prev_v) begin
            chk("rsp_latency", 64'(cyc - acc_cyc), 64'(sb[0].lat));
            chk("cell_en_cycles", 64'(cen), 64'(sb[0].cen));
          end
          if (rsp1_valid ? rsp1_ready : rsp0_ready) begin
            void'(sb.pop_front());
            last_hs = cyc;
          end
        end
      end
      prev_v = rsp0_valid || rsp1_valid;
    end
  end

  task automatic send(input bit who, input logic [31:0] a,
                      input logic [31:0] b);
    int n;
    bit rdy;
    @(posedge clk);
    #1;
    if (who) begin
      req1_valid = 1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b;
    end
    n = 0;
    do begin
      @(negedge clk);
      rdy = who ? req1_ready : req0_ready;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (who) req1_valid = 0;
    else     req0_valid = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_zero_out(input string tag);
    chk({tag, "_ctl"}, {req0_ready, req1_ready, rsp0_valid,
        rsp1_valid, cell_en, busy}, 0);
    chk({tag, "_src"}, {cell_src1, cell_src2}, 0);
    chk({tag, "_data"}, rsp_data, 0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    chk_zero_out("reset");
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1;
  endtask

  initial begin
    reset_n = 1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    #2;
    do_reset();

    send(0, 32'd3, 32'd5);
    wait_idle();
    send(1, 32'h0001_2345, 32'h0001_0001);
    wait_idle();
    send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    send(1, 32'h0001_0000, 32'h0001_0000);
    wait_idle();
    send(0, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_idle();

    // Both requesters pushing continuously: grants must alternate from 0.
    do_reset();
    grants.delete();
    fork
      begin
        send(0, 32'd11, 32'd13);
        send(0, 32'h8000_0001, 32'd3);
      end
      begin
        send(1, 32'd17, 32'd19);
        send(1, 32'h0000_FFFF, 32'h0000_FFFF);
      end
    join
    wait_idle();
    chk("grant_count", 64'(grants.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < grants.size())
        chk($sformatf("grant_%0d", i), grants[i], i % 2);

    // Owner stalls its response while the other requester waits.
    rsp0_ready = 0;
    send(0, 32'd7, 32'd9);
    fork
      send(1, 32'h0002_0003, 32'h0004_0005);
    join_none
    begin
      int n;
      n = 0;
      while (!rsp0_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (10) begin
      @(negedge clk);
      chk("stall_rsp0_valid", rsp0_valid, 1);
      chk("stall_data", rsp_data, 32'd63);
      chk("stall_req1_ready", req1_ready, 0);
    end
    chk_b2b = 1;
    @(posedge clk);
    #1;
    rsp0_ready = 1;
    wait fork;
    wait_idle();
    chk("b2b_seen", chk_b2b, 0);

    // Reset while the cell is enabled drops the in-flight op.
    send(0, 32'h0000_1234, 32'h0000_5678);
    chk("mul_before_reset", cell_en, 1);
    do_reset();
    chk("no_stale_rsp", {rsp0_valid, rsp1_valid}, 0);
    send(0, 32'h0000_0100, 32'h0000_0200);
    wait_idle();

    send(1, 32'd0, 32'hDEAD_BEEF);
    wait_idle();

    chk("sb_drained", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
